// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the front end: opcode constants, NOP encoding,
// fetch FSM state encoding and instruction field helpers.
package riscv_pkg;

   localparam logic [6:0] OPCODE_R      = 7'b0110011;
   localparam logic [6:0] OPCODE_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FETCH = 1'b0,
      WAIT  = 1'b1
   } fetch_state_e;

   function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
      return instr[14:12];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: imem request/response, branch redirect
// and the decode-facing output slot. master = fetch unit, slave = environment.
interface fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic [6:0]  if_opcode;
   logic [2:0]  if_funct3;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_pc,
      output if_valid, if_pc, if_instr, if_opcode, if_funct3,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_pc,
      input  if_valid, if_pc, if_instr, if_opcode, if_funct3,
      output if_ready
   );

endinterface

// File: rtl/fetch_unit_out_slot.sv
// One-entry valid/ready holding register between fetch and decode.
// Flush wins over load and over a consume.
module fetch_out_slot (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_instr <= 32'h0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM,
// redirect squash with stale-response drop, and the decode output slot.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic         r_drop;
   logic         w_drop_nxt;
   logic         w_load;
   logic         w_req_valid;
   logic         w_slot_free;
   logic         w_if_valid;
   logic [31:0]  w_if_pc;
   logic [31:0]  w_if_instr;
   logic [1:0]   w_unused_redirect_lsb;

   assign w_unused_redirect_lsb = bus.redirect_pc[1:0];
   assign w_slot_free           = ~w_if_valid | bus.if_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
      end
   end

   // Redirect overrides everything; a redirect in WAIT either swallows a
   // coincident response or arms drop for the one still in flight.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drop_nxt  = r_drop;
      w_load      = 1'b0;
      w_req_valid = 1'b0;
      if (bus.redirect_valid) begin
         w_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
         if (r_state == WAIT) begin
            if (bus.imem_resp_valid) begin
               w_state_nxt = FETCH;
               w_drop_nxt  = 1'b0;
            end else begin
               w_drop_nxt  = 1'b1;
            end
         end
      end else begin
         case (r_state)
            FETCH: begin
               w_req_valid = rst_n & w_slot_free;
               if (w_req_valid && bus.imem_req_ready) w_state_nxt = WAIT;
            end
            WAIT: begin
               if (bus.imem_resp_valid) begin
                  w_state_nxt = FETCH;
                  w_drop_nxt  = 1'b0;
                  if (!r_drop) begin
                     w_load   = 1'b1;
                     w_pc_nxt = r_pc + PC_STEP;
                  end
               end
            end
            default: w_state_nxt = FETCH;
         endcase
      end
   end

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;

   fetch_out_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (bus.redirect_valid),
      .i_load  (w_load),
      .i_pc    (r_pc),
      .i_instr (bus.imem_resp_data),
      .i_ready (bus.if_ready),
      .o_valid (w_if_valid),
      .o_pc    (w_if_pc),
      .o_instr (w_if_instr)
   );

   assign bus.if_valid  = w_if_valid;
   assign bus.if_pc     = w_if_pc;
   assign bus.if_instr  = w_if_instr;
   assign bus.if_opcode = instr_opcode(w_if_instr);
   assign bus.if_funct3 = instr_funct3(w_if_instr);

endmodule
